naxis_sequencer: RTL and testbench
==================================

NAXIS_SEQUENCER -- requirements
Module: naxis_sequencer

Parameters
REQ-001 SHALL have parameter NAXES, default 6: number of motor axes (1..16).
REQ-002 SHALL have parameter DEPTH, default 8: segment queue entries, power of 2, min 2.
REQ-003 SHALL have parameter TICK_DIV, default 200: clk cycles per motion tick (min 8).

Interface
REQ-004 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-005 clk  in  1  system clock (10 MHz).
REQ-006 rst  in  1  sync active-high reset.
REQ-007 wrValid  in  1  host pushes one coordinated segment.
REQ-008 wrReady  out  1  queue not full.
REQ-009 wrMask  in  NAXES  axes participating in the segment.
REQ-010 wrDir  in  2*NAXES  per-axis signed direction.
REQ-011 wrAccel  in  32*NAXES  per-axis signed acceleration.
REQ-012 wrAccelSamples / wrCruiseSamples  in  32*NAXES each  per-axis sample counts.
REQ-013 run  in  1  dispatch enable.
REQ-014 flush  in  1  one-cycle pulse, empties the queue.
REQ-015 alarm  in  NAXES  per-axis limiter alarms.
REQ-016 haltClear  in  1  one-cycle pulse, clears the halt.
REQ-017 busy  in  NAXES  per-axis motion busy.
REQ-018 prgmReq  out  NAXES  per-axis program request.
REQ-019 prgmAck  in  NAXES  per-axis one-cycle acknowledge.
REQ-020 prgmDir, prgmAccel, prgmAccelSamples, prgmCruiseSamples  out  same widths as wr*  the segment being dispatched.
REQ-021 ph1..ph4  out  1 each  tick phase enables.
REQ-022 count  out  clog2(DEPTH)+1  queue occupancy.
REQ-023 segDone  out  1  one-cycle pulse when a segment completes.
REQ-024 halted  out  1  dispatch halted by alarm.
REQ-025 overflow  out  1  sticky flag: a push was attempted while full.

Function
REQ-026 Tick counter SHALL count 0..TICK_DIV-1 and wrap; ph1..ph4 are registered pulses one cycle after the counter reads 0, 1, 2 and 3 respectively.
REQ-027 Queue SHALL be a FIFO; a push is accepted when wrValid&&wrReady; wrReady = (count<DEPTH); a pop in the same cycle does not free space for the push.
REQ-028 wrValid while full SHALL drop the data and set overflow; overflow clears only on rst.
REQ-029 Push and pop in the same cycle (not full) SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-030 flush SHALL zero count and both pointers the next cycle; a push in the flush cycle is discarded without setting overflow; an in-flight segment completes normally.
REQ-031 FSM states: IDLE, ISSUE, WAIT_ACK, SETTLE, WAIT_BUSY.
REQ-032 IDLE->ISSUE SHALL occur when run && !halted && count>0 && (busy==0); the head entry is popped and latched into the prgm* outputs in that cycle.
REQ-033 ISSUE SHALL assert prgmReq[i] = mask[i] for one cycle into WAIT_ACK; a segment with mask 0 goes straight to SETTLE.
REQ-034 In WAIT_ACK, prgmReq[i] SHALL drop the cycle after prgmAck[i]; prgm* data stays stable until all requests drop; the FSM then enters SETTLE.
REQ-035 Acks on non-requested axes SHALL be ignored.
REQ-036 SETTLE SHALL wait for the next ph4, then enter WAIT_BUSY.
REQ-037 WAIT_BUSY SHALL wait for (busy & mask)==0, then pulse segDone and return to IDLE.
REQ-038 Consecutive segments SHALL dispatch with no idle ticks beyond the FSM latency: IDLE to ISSUE is one cycle.
REQ-039 Any alarm bit high SHALL set halted the next cycle.
REQ-040 While halted, no new pop SHALL occur; an in-flight handshake still completes.
REQ-041 haltClear SHALL clear halted only if alarm==0 in the same cycle.
REQ-042 Deasserting run SHALL only block new pops.

Reset
REQ-043 On rst: FSM=IDLE; count, pointers and the tick counter =0; prgmReq=0; all prgm* data=0; ph1..ph4, segDone, halted and overflow =0.
REQ-044 rst mid-handshake SHALL abort the segment with no segDone pulse, and SHALL discard queue contents.

Verification
REQ-045 NAXES=6, push 3 segments with mask 6'b000011, acks 2 cycles after each req, busy held for 1 tick -> 3 segDone pulses in order; prgm* values match the pushed values.
REQ-046 DEPTH=8, 9 pushes with run=0 -> count=8, wrReady=0, overflow=1, and the 9th entry is never dispatched.
REQ-047 Push on one axis, alarm[2] pulsed while in WAIT_ACK -> the handshake finishes, halted=1, and the next entry stays queued; haltClear with alarm=0 -> dispatch resumes.
REQ-048 flush with 5 entries queued and one in flight -> count=0 next cycle; exactly one segDone follows.
REQ-049 Push and pop in the same cycle at count=DEPTH-1 -> count stays DEPTH-1; pointer wrap checked over 20 entries.
REQ-050 TICK_DIV=200 -> ph1 period is 200 cycles, and ph4 arrives 3 cycles after ph1.

Source files
------------

// File: rtl/naxis_sequencer_if.sv
// Host, axis and status signals of the multi-axis segment sequencer.
// master: host/axis side that pushes segments and answers requests.
// slave: the sequencer itself.
interface naxis_sequencer_if #(
    parameter int unsigned NAXES = 6,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                    wrValid;
    logic                    wrReady;
    logic [NAXES-1:0]        wrMask;
    logic [2*NAXES-1:0]      wrDir;
    logic [32*NAXES-1:0]     wrAccel;
    logic [32*NAXES-1:0]     wrAccelSamples;
    logic [32*NAXES-1:0]     wrCruiseSamples;
    logic                    run;
    logic                    flush;
    logic [NAXES-1:0]        alarm;
    logic                    haltClear;
    logic [NAXES-1:0]        busy;
    logic [NAXES-1:0]        prgmReq;
    logic [NAXES-1:0]        prgmAck;
    logic [2*NAXES-1:0]      prgmDir;
    logic [32*NAXES-1:0]     prgmAccel;
    logic [32*NAXES-1:0]     prgmAccelSamples;
    logic [32*NAXES-1:0]     prgmCruiseSamples;
    logic                    ph1;
    logic                    ph2;
    logic                    ph3;
    logic                    ph4;
    logic [CW-1:0]           count;
    logic                    segDone;
    logic                    halted;
    logic                    overflow;

    modport master (
        output wrValid, wrMask, wrDir, wrAccel, wrAccelSamples, wrCruiseSamples,
        output run, flush, alarm, haltClear, busy, prgmAck,
        input  wrReady, prgmReq, prgmDir, prgmAccel, prgmAccelSamples, prgmCruiseSamples,
        input  ph1, ph2, ph3, ph4, count, segDone, halted, overflow
    );

    modport slave (
        input  wrValid, wrMask, wrDir, wrAccel, wrAccelSamples, wrCruiseSamples,
        input  run, flush, alarm, haltClear, busy, prgmAck,
        output wrReady, prgmReq, prgmDir, prgmAccel, prgmAccelSamples, prgmCruiseSamples,
        output ph1, ph2, ph3, ph4, count, segDone, halted, overflow
    );
endinterface

// File: rtl/naxis_sequencer.sv
// Coordinated multi-axis segment sequencer: a segment FIFO feeding a
// request/ack dispatcher that is paced by a divided motion tick.
module naxis_sequencer #(
    parameter int unsigned NAXES    = 6,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = 200
) (
    input logic              clk,
    input logic              rst,
    naxis_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TICK_DIV);
    // Entry layout: mask, dir, accel, accelSamples, cruiseSamples.
    localparam int unsigned EW = NAXES + 2 * NAXES + 96 * NAXES;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_ACK  = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] WAIT_BUSY = 3'd4;

    logic [TW-1:0]        tickQ;
    logic                 ph1Q, ph2Q, ph3Q, ph4Q;
    logic [EW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wrPtrQ, rdPtrQ;
    logic [CW-1:0]        countQ;
    logic                 overflowQ, haltedQ;
    logic                 wrReady, pushEn, popEn;
    logic [2:0]           stateQ, stateD;
    logic [NAXES-1:0]     reqQ, reqD;
    logic                 segDoneQ, segDoneD;
    logic [NAXES-1:0]     maskQ;
    logic [2*NAXES-1:0]   dirQ;
    logic [32*NAXES-1:0]  accelQ, accSampQ, cruSampQ;

    // Free-running motion tick counter.
    always_ff @(posedge clk) begin
        if (rst || tickQ == TW'(TICK_DIV - 1)) tickQ <= '0;
        else                                   tickQ <= tickQ + 1'b1;
    end

    // Phase enables, registered one cycle after the counter reads 0..3.
    always_ff @(posedge clk) begin
        if (rst) begin
            {ph1Q, ph2Q, ph3Q, ph4Q} <= '0;
        end else begin
            ph1Q <= (tickQ == TW'(0));
            ph2Q <= (tickQ == TW'(1));
            ph3Q <= (tickQ == TW'(2));
            ph4Q <= (tickQ == TW'(3));
        end
    end

    // Queue handshake; a same-cycle pop never makes room for the push.
    always_comb begin
        wrReady = (countQ < CW'(DEPTH));
        pushEn  = bus.wrValid && wrReady && !bus.flush;
        popEn   = (stateQ == IDLE) && bus.run && !haltedQ && (countQ != '0) &&
                  (bus.busy == '0) && !bus.flush;
    end

    // Segment storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (pushEn && !rst) begin
            mem[wrPtrQ] <= {bus.wrMask, bus.wrDir, bus.wrAccel, bus.wrAccelSamples,
                            bus.wrCruiseSamples};
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (pushEn) wrPtrQ <= wrPtrQ + 1'b1;
            if (popEn)  rdPtrQ <= rdPtrQ + 1'b1;
            unique case ({pushEn, popEn})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

    // Sticky overflow and alarm halt; a push dropped by flush is not an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflowQ <= 1'b0;
            haltedQ   <= 1'b0;
        end else begin
            if (bus.wrValid && !wrReady && !bus.flush) overflowQ <= 1'b1;
            if (bus.alarm != '0)    haltedQ <= 1'b1;
            else if (bus.haltClear) haltedQ <= 1'b0;
        end
    end

    // Dispatch FSM next state.
    always_comb begin
        stateD   = stateQ;
        reqD     = reqQ;
        segDoneD = 1'b0;
        case (stateQ)
            IDLE: if (popEn) stateD = ISSUE;
            ISSUE: begin
                reqD   = maskQ;
                stateD = (maskQ == '0) ? SETTLE : WAIT_ACK;
            end
            WAIT_ACK: begin
                // Acks on axes not requested fall away in the mask.
                reqD = reqQ & ~bus.prgmAck;
                if (reqD == '0) stateD = SETTLE;
            end
            SETTLE: if (ph4Q) stateD = WAIT_BUSY;
            WAIT_BUSY: begin
                if ((bus.busy & maskQ) == '0) begin
                    stateD   = IDLE;
                    segDoneD = 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // FSM state, requests and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= IDLE;
            reqQ     <= '0;
            segDoneQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            reqQ     <= reqD;
            segDoneQ <= segDoneD;
        end
    end

    // Head entry is latched on pop and held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            {maskQ, dirQ, accelQ, accSampQ, cruSampQ} <= '0;
        end else if (popEn) begin
            {maskQ, dirQ, accelQ, accSampQ, cruSampQ} <= mem[rdPtrQ];
        end
    end

    // Drive interface outputs.
    always_comb begin
        bus.wrReady           = wrReady;
        bus.prgmReq           = reqQ;
        bus.prgmDir           = dirQ;
        bus.prgmAccel         = accelQ;
        bus.prgmAccelSamples  = accSampQ;
        bus.prgmCruiseSamples = cruSampQ;
        bus.ph1               = ph1Q;
        bus.ph2               = ph2Q;
        bus.ph3               = ph3Q;
        bus.ph4               = ph4Q;
        bus.count             = countQ;
        bus.segDone           = segDoneQ;
        bus.halted            = haltedQ;
        bus.overflow          = overflowQ;
    end
endmodule

// File: tb/tb_naxis_sequencer.sv
// Self-checking bench for naxis_sequencer: table of push/flush vectors,
// directed multi-cycle scenarios and randomized rounds against a queue model.
module tb_naxis_sequencer;
    localparam int NAXES    = 6;
    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 200;
    localparam int DW       = 2 * NAXES;
    localparam int AW       = 32 * NAXES;

    typedef struct {
        logic [NAXES-1:0] mask;
        logic [DW-1:0]    dir;
        logic [AW-1:0]    accel;
        logic [AW-1:0]    accS;
        logic [AW-1:0]    cruS;
    } seg_t;

    typedef struct {
        bit push;
        bit flush;
        int expCount;
        bit expReady;
        bit expOvf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    naxis_sequencer_if #(.NAXES(NAXES), .DEPTH(DEPTH)) bus ();

    naxis_sequencer #(.NAXES(NAXES), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks       = 0;
    int   errors       = 0;
    int   segDoneCount = 0;
    int   cyc          = 0;
    int   ackDelay     = 2;
    int   busyLen      = TICK_DIV;
    seg_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic seg_t randSeg(input logic [NAXES-1:0] mask);
        seg_t s;
        s.mask = mask;
        s.dir  = DW'($urandom);
        for (int k = 0; k < NAXES; k++) begin
            s.accel[32*k +: 32] = $urandom;
            s.accS[32*k +: 32]  = $urandom;
            s.cruS[32*k +: 32]  = $urandom;
        end
        return s;
    endfunction

    task automatic drive(input seg_t s);
        bus.wrMask          = s.mask;
        bus.wrDir           = s.dir;
        bus.wrAccel         = s.accel;
        bus.wrAccelSamples  = s.accS;
        bus.wrCruiseSamples = s.cruS;
    endtask

    task automatic pushSeg(input seg_t s, input bit accept);
        drive(s);
        bus.wrValid = 1'b1;
        @(negedge clk);
        bus.wrValid = 1'b0;
        if (accept) sb.push_back(s);
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.wrValid   = 1'b0;
        bus.run       = 1'b0;
        bus.flush     = 1'b0;
        bus.alarm     = '0;
        bus.haltClear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (bus.prgmReq == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " request seen"}, 192'(bus.prgmReq != '0), 192'(1));
    endtask

    task automatic waitDone(input int target, input int limit);
        int n = 0;
        while (segDoneCount < target && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Run the queue empty, then watch long enough for any stray completion.
    task automatic drain(input string name);
        int n = 0;
        bus.run = 1'b1;
        while (sb.size() > 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain entries left"}, 192'(sb.size()), 192'(0));
        sb.delete();
        repeat (2 * TICK_DIV + 50) @(negedge clk);
        bus.run = 1'b0;
        check({name, " count after drain"}, 192'(bus.count), 192'(0));
    endtask

    // Completion scoreboard: each segDone must retire the oldest queued segment.
    initial begin : monitor
        logic [NAXES-1:0] reqSeen;
        seg_t e;
        reqSeen = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                reqSeen = '0;
            end else begin
                reqSeen |= bus.prgmReq;
                if (bus.segDone) begin
                    segDoneCount++;
                    if (sb.size() == 0) begin
                        check("segDone with empty model queue", 192'(bus.segDone), 192'(0));
                    end else begin
                        e = sb.pop_front();
                        check("requested axes", 192'(reqSeen), 192'(e.mask));
                        check("prgmDir", 192'(bus.prgmDir), 192'(e.dir));
                        check("prgmAccel", bus.prgmAccel, e.accel);
                        check("prgmAccelSamples", bus.prgmAccelSamples, e.accS);
                        check("prgmCruiseSamples", bus.prgmCruiseSamples, e.cruS);
                    end
                    reqSeen = '0;
                end
            end
        end
    end

    // Axis responder: ack each request after ackDelay, then report busy for busyLen.
    initial begin : responder
        int ackCnt[NAXES];
        int busyCnt[NAXES];
        bus.prgmAck = '0;
        bus.busy    = '0;
        for (int i = 0; i < NAXES; i++) begin
            ackCnt[i]  = -1;
            busyCnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NAXES; i++) begin
                if (rst) begin
                    ackCnt[i]      = -1;
                    busyCnt[i]     = 0;
                    bus.prgmAck[i] = 1'b0;
                    bus.busy[i]    = 1'b0;
                end else begin
                    bus.prgmAck[i] = 1'b0;
                    if (busyCnt[i] > 0) busyCnt[i]--;
                    if (bus.prgmReq[i] && ackCnt[i] < 0) ackCnt[i] = ackDelay;
                    if (ackCnt[i] == 0) begin
                        bus.prgmAck[i] = 1'b1;
                        ackCnt[i]      = -1;
                        busyCnt[i]     = busyLen;
                    end else if (ackCnt[i] > 0) begin
                        ackCnt[i]--;
                    end
                    bus.busy[i] = (busyCnt[i] > 0);
                end
            end
        end
    end

    initial begin : main
        vec_t tbl[14];
        seg_t s;
        int   t1, n, d0, modelCount, target, sent;
        bit   modelOvf, valid;

        // Push/flush vectors with run low: counts, ready and sticky overflow.
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, i + 1, (i + 1) < DEPTH, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 2, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 0, 1'b1, 1'b1};

        rst           = 1'b1;
        bus.wrValid   = 1'b0;
        bus.run       = 1'b0;
        bus.flush     = 1'b0;
        bus.alarm     = '0;
        bus.haltClear = 1'b0;
        drive(randSeg('0));

        // Reset values.
        repeat (2) @(negedge clk);
        check("reset count", 192'(bus.count), 192'(0));
        check("reset wrReady", 192'(bus.wrReady), 192'(1));
        check("reset overflow", 192'(bus.overflow), 192'(0));
        check("reset halted", 192'(bus.halted), 192'(0));
        check("reset prgmReq", 192'(bus.prgmReq), 192'(0));
        check("reset segDone", 192'(bus.segDone), 192'(0));
        check("reset phases", 192'({bus.ph1, bus.ph2, bus.ph3, bus.ph4}), 192'(0));
        check("reset prgmAccel", bus.prgmAccel, 192'(0));
        rst = 1'b0;

        // Tick phases: ph1..ph4 on consecutive cycles, ph1 period TICK_DIV.
        @(negedge clk);
        t1 = cyc;
        check("ph1 first cycle after reset", 192'({bus.ph1, bus.ph2}), 192'(2'b10));
        @(negedge clk);
        check("ph2 follows ph1", 192'({bus.ph1, bus.ph2, bus.ph3}), 192'(3'b010));
        @(negedge clk);
        check("ph3 follows ph2", 192'({bus.ph2, bus.ph3, bus.ph4}), 192'(3'b010));
        @(negedge clk);
        check("ph4 three cycles after ph1", 192'(cyc - t1), 192'(3));
        check("ph4 pulse", 192'({bus.ph3, bus.ph4}), 192'(2'b01));
        n = 0;
        @(negedge clk);
        while (!bus.ph1 && n < 2 * TICK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("ph1 period", 192'(cyc - t1), 192'(TICK_DIV));

        // Table-driven queue vectors.
        doReset();
        for (int i = 0; i < 14; i++) begin
            drive(randSeg(NAXES'($urandom)));
            bus.wrValid = tbl[i].push;
            bus.flush   = tbl[i].flush;
            @(negedge clk);
            check($sformatf("vec%0d count", i), 192'(bus.count), 192'(tbl[i].expCount));
            check($sformatf("vec%0d wrReady", i), 192'(bus.wrReady), 192'(tbl[i].expReady));
            check($sformatf("vec%0d overflow", i), 192'(bus.overflow), 192'(tbl[i].expOvf));
        end
        bus.wrValid = 1'b0;
        bus.flush   = 1'b0;

        // Three two-axis segments, ack two cycles after request, busy one tick.
        doReset();
        ackDelay = 2;
        busyLen  = TICK_DIV;
        for (int i = 0; i < 3; i++) pushSeg(randSeg(6'b000011), 1'b1);
        d0 = segDoneCount;
        drain("three segments");
        check("three segDone pulses", 192'(segDoneCount - d0), 192'(3));

        // Nine pushes into eight entries; the ninth must never be dispatched.
        doReset();
        busyLen = 10;
        for (int i = 0; i < 9; i++) pushSeg(randSeg(NAXES'($urandom)), i < DEPTH);
        check("full count", 192'(bus.count), 192'(DEPTH));
        check("full wrReady", 192'(bus.wrReady), 192'(0));
        check("full overflow", 192'(bus.overflow), 192'(1));
        d0 = segDoneCount;
        drain("overfull");
        check("overfull dispatched", 192'(segDoneCount - d0), 192'(DEPTH));
        check("overflow sticky", 192'(bus.overflow), 192'(1));

        // Push and pop together at DEPTH-1.
        doReset();
        for (int i = 0; i < DEPTH - 1; i++) pushSeg(randSeg(NAXES'($urandom)), 1'b1);
        s = randSeg(NAXES'($urandom));
        drive(s);
        bus.wrValid = 1'b1;
        bus.run     = 1'b1;
        @(negedge clk);
        bus.wrValid = 1'b0;
        bus.run     = 1'b0;
        sb.push_back(s);
        check("push+pop at DEPTH-1 count", 192'(bus.count), 192'(DEPTH - 1));
        drain("push+pop");

        // Alarm during handshake: segment completes, next entry held until clear.
        doReset();
        ackDelay = 2;
        busyLen  = 20;
        pushSeg(randSeg(6'b000001), 1'b1);
        pushSeg(randSeg(6'b000001), 1'b1);
        d0 = segDoneCount;
        bus.run = 1'b1;
        waitReq("alarm");
        bus.alarm = 6'b000100;
        @(negedge clk);
        bus.alarm = '0;
        check("halted after alarm", 192'(bus.halted), 192'(1));
        waitDone(d0 + 1, 3 * TICK_DIV);
        repeat (TICK_DIV) @(negedge clk);
        check("in-flight finished while halted", 192'(segDoneCount - d0), 192'(1));
        check("next entry held", 192'(bus.count), 192'(1));
        check("no request while halted", 192'(bus.prgmReq), 192'(0));
        bus.haltClear = 1'b1;
        bus.alarm     = 6'b100000;
        @(negedge clk);
        bus.haltClear = 1'b0;
        bus.alarm     = '0;
        check("haltClear ignored with alarm", 192'(bus.halted), 192'(1));
        bus.haltClear = 1'b1;
        @(negedge clk);
        bus.haltClear = 1'b0;
        check("haltClear releases", 192'(bus.halted), 192'(0));
        drain("after halt");
        check("resumed segment done", 192'(segDoneCount - d0), 192'(2));

        // Flush with five queued and one in flight.
        doReset();
        ackDelay = 3;
        busyLen  = 50;
        for (int i = 0; i < 6; i++) pushSeg(randSeg(NAXES'($urandom) | 6'b000001), 1'b1);
        bus.run = 1'b1;
        waitReq("flush");
        check("five queued behind in-flight", 192'(bus.count), 192'(5));
        d0 = segDoneCount;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush empties queue", 192'(bus.count), 192'(0));
        while (sb.size() > 1) void'(sb.pop_back());
        repeat (3 * TICK_DIV) @(negedge clk);
        bus.run = 1'b0;
        check("one segDone after flush", 192'(segDoneCount - d0), 192'(1));

        // Reset mid-handshake aborts without segDone.
        doReset();
        ackDelay = 4;
        pushSeg(randSeg(6'b000010), 1'b1);
        pushSeg(randSeg(6'b000010), 1'b1);
        bus.run = 1'b1;
        waitReq("mid reset");
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        d0 = segDoneCount;
        check("reset clears requests", 192'(bus.prgmReq), 192'(0));
        check("reset discards queue", 192'(bus.count), 192'(0));
        repeat (3 * TICK_DIV) @(negedge clk);
        check("no segDone after reset", 192'(segDoneCount - d0), 192'(0));
        bus.run = 1'b0;

        // Randomized rounds without reset; pointers wrap across rounds.
        doReset();
        modelOvf = 1'b0;
        for (int r = 0; r < 4; r++) begin
            modelCount = 0;
            target     = $urandom_range(5, 11);
            sent       = 0;
            while (sent < target) begin
                valid = ($urandom_range(0, 3) != 0);
                s = randSeg(($urandom_range(0, 7) == 0) ? '0 : NAXES'($urandom));
                drive(s);
                bus.wrValid = valid;
                @(negedge clk);
                if (valid) begin
                    sent++;
                    if (modelCount < DEPTH) begin
                        sb.push_back(s);
                        modelCount++;
                    end else begin
                        modelOvf = 1'b1;
                    end
                end
                check("rand count", 192'(bus.count), 192'(modelCount));
                check("rand wrReady", 192'(bus.wrReady), 192'(modelCount < DEPTH));
                check("rand overflow", 192'(bus.overflow), 192'(modelOvf));
            end
            bus.wrValid = 1'b0;
            ackDelay = $urandom_range(0, 4);
            busyLen  = $urandom_range(0, 250);
            d0 = segDoneCount;
            drain($sformatf("round%0d", r));
            check("round segDone total", 192'(segDoneCount - d0), 192'(modelCount));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
